// File: rtl/signed_accum.sv
// Frame accumulator: sums N_SAMPLES signed samples with saturation.
// The result is held with a sticky overflow flag until the consumer takes it.
module signed_accum #(
    parameter int DATA_W    = 4,
    parameter int ACC_W     = 6,
    parameter int N_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(N_SAMPLES - 1);
    localparam logic [ACC_W-1:0] SUM_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SUM_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] sum_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;

    logic             accept;
    logic             take;
    logic             last_sample;
    logic [ACC_W:0]   sum_wide;
    logic             pos_clamp;
    logic             neg_clamp;
    logic [ACC_W-1:0] sum_sat;

    assign accept      = in_valid && in_ready;
    assign take        = out_valid && out_ready;
    assign last_sample = (count_reg == LAST_COUNT);

    // One guard bit is enough: a single sample can at most push the sum one
    // range beyond ACC_W, so disagreement of the top two bits means overflow.
    assign sum_wide  = {sum_reg[ACC_W-1], sum_reg}
                     + {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign pos_clamp = ~sum_wide[ACC_W] &  sum_wide[ACC_W-1];
    assign neg_clamp =  sum_wide[ACC_W] & ~sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        if (pos_clamp) begin
            sum_sat = SUM_MAX;
        end else if (neg_clamp) begin
            sum_sat = SUM_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ACCUM;
        end else begin
            case (state_reg)
                ACCUM:   if (accept && last_sample) state_next = HOLD;
                HOLD:    if (take) state_next = ACCUM;
                default: state_next = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_reg == ACCUM);
        out_valid = (state_reg == HOLD);
        out_sum   = sum_reg;
        out_ovf   = ovf_reg;
    end

    // Clear outranks both handshakes, so a sample offered with clear is lost.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            sum_reg   <= sum_sat;
            count_reg <= count_reg + 1'b1;
            ovf_reg   <= ovf_reg | pos_clamp | neg_clamp;
        end else if (take) begin
            sum_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_accum.sv
// Directed bench for signed_accum with the default 4-bit samples, 6-bit sum
// and 8-sample frames; expected values are hand-computed.
module tb_signed_accum;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sum;
    logic       out_ovf;

    int checks;
    int errors;

    signed_accum #(
        .DATA_W    (4),
        .ACC_W     (6),
        .N_SAMPLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    function automatic int sum_now();
        return int'($signed(out_sum));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d);
        in_valid = 1'b1;
        in_data  = 4'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_sum"}, sum_now(), 0);
        check({tag, "_ovf"}, int'(out_ovf), 0);
    endtask

    int frame_a[8] = '{7, -8, 3, 1, -2, 0, 5, -4};
    int held_sum;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // No-saturation frame with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(frame_a[i]);
            tick();
        end
        in_valid = 1'b0;
        check("nosat_valid", int'(out_valid), 1);
        check("nosat_sum", sum_now(), 2);
        check("nosat_ovf", int'(out_ovf), 0);
        tick();
        out_ready = 1'b0;
        check_idle("nosat_after");

        // Positive saturation: 28 after four samples, clamps on the fifth.
        for (int i = 0; i < 4; i++) push(7);
        check("pos4_sum", sum_now(), 28);
        check("pos4_ovf", int'(out_ovf), 0);
        push(7);
        check("pos5_sum", sum_now(), 31);
        check("pos5_ovf", int'(out_ovf), 1);
        for (int i = 0; i < 3; i++) push(7);
        check("pos_valid", int'(out_valid), 1);
        check("pos_sum", sum_now(), 31);
        check("pos_ovf", int'(out_ovf), 1);
        take();
        check_idle("pos_after");

        // Negative saturation: -32 reached exactly, overflow on the fifth.
        for (int i = 0; i < 4; i++) push(-8);
        check("neg4_sum", sum_now(), -32);
        check("neg4_ovf", int'(out_ovf), 0);
        push(-8);
        check("neg5_ovf", int'(out_ovf), 1);
        for (int i = 0; i < 3; i++) push(-8);
        check("neg_valid", int'(out_valid), 1);
        check("neg_sum", sum_now(), -32);
        check("neg_ovf", int'(out_ovf), 1);
        take();

        // Backpressure: samples offered during HOLD must not be counted.
        for (int i = 0; i < 8; i++) push(2);
        held_sum = sum_now();
        check("bp_sum", held_sum, 16);
        in_valid = 1'b1;
        in_data  = 4'd3;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_hold_sum", sum_now(), 16);
        end
        take();
        in_valid = 1'b0;
        check_idle("bp_after");
        for (int i = 0; i < 7; i++) push(1);
        check("bp_next7_valid", int'(out_valid), 0);
        push(1);
        check("bp_next8_valid", int'(out_valid), 1);
        check("bp_next_sum", sum_now(), 8);
        take();

        // Clear mid-frame, asserted together with a sample.
        for (int i = 0; i < 3; i++) push(7);
        check("clr_pre_sum", sum_now(), 21);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd7;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_idle("clr");
        for (int i = 0; i < 7; i++) push(1);
        check("clr7_valid", int'(out_valid), 0);
        push(1);
        check("clr8_valid", int'(out_valid), 1);
        check("clr_sum", sum_now(), 8);
        take();

        // Clear in HOLD beats a simultaneous take and still empties the frame.
        for (int i = 0; i < 8; i++) push(-3);
        check("clrhold_sum", sum_now(), -24);
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        check_idle("clrhold");

        // Reset in HOLD.
        for (int i = 0; i < 8; i++) push(7);
        check("rsthold_valid", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rsthold");

        // Reset mid-frame discards the partial sum and count.
        for (int i = 0; i < 3; i++) push(5);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd5;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_idle("rstmid");
        for (int i = 0; i < 7; i++) push(1);
        check("rstmid7_valid", int'(out_valid), 0);
        push(1);
        check("rstmid_sum", sum_now(), 8);
        take();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_accum.md
SIGNED_ACCUM -- requirements
Module: signed_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 4: width of each two's-complement input sample.
REQ-002 SHALL have parameter ACC_W, default 6: width of the signed accumulator; ACC_W > DATA_W.
REQ-003 SHALL have parameter N_SAMPLES, default 8: number of samples per frame, at least 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port clear, input, 1: synchronous frame abort.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-008 SHALL have port in_data, input, DATA_W: signed two's-complement sample, as produced by the upstream two_complement stage.
REQ-009 SHALL have port in_ready, output, 1: the block can accept a sample this cycle.
REQ-010 SHALL have port out_valid, output, 1: a frame result is being presented.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result this cycle.
REQ-012 SHALL have port out_sum, output, ACC_W: signed, saturated frame sum.
REQ-013 SHALL have port out_ovf, output, 1: sticky flag; saturation occurred at least once in this frame.

Function
REQ-014 SHALL implement a two-state FSM with states ACCUM and HOLD.
REQ-015 SHALL hold in_ready=1 and out_valid=0 in ACCUM, and in_ready=0 and out_valid=1 in HOLD; both are decoded from state.
REQ-016 SHALL accept a sample only when in_valid and in_ready are both 1 on the same edge.
REQ-017 SHALL ignore in_data when no sample is accepted.
REQ-018 SHALL, on each accepted sample, sign-extend in_data to ACC_W+1 bits and add it to the sign-extended sum at full precision.
REQ-019 SHALL store the sum as follows: above 2^(ACC_W-1)-1 stores +max; below -2^(ACC_W-1) stores -min; otherwise stores the exact result.
REQ-020 SHALL set out_ovf on any clamp; out_ovf stays set until the frame ends.
REQ-021 SHALL keep a sample counter of width clog2(N_SAMPLES) that increments on each accepted sample.
REQ-022 SHALL, on the accept that makes the count N_SAMPLES, move to HOLD; out_valid rises the next cycle.
REQ-023 SHALL give latency of one cycle from the last accepted sample to out_valid, with out_sum already including that sample.
REQ-024 SHALL keep out_sum and out_ovf stable in HOLD until the result is taken.
REQ-025 SHALL, on out_valid and out_ready both 1 in HOLD: zero the sum, counter and out_ovf, and return to ACCUM; in_ready is 1 the next cycle.
REQ-026 SHALL have no effect from out_ready in ACCUM.
REQ-027 SHALL not allow a back-to-back accept in the HOLD-exit cycle, because in_ready=0 in that cycle.
REQ-028 SHALL let clear=1 zero the sum, counter and out_ovf and force ACCUM, from either state.
REQ-029 SHALL give clear priority over any accept or output handshake in the same cycle; no sample is accepted that cycle.
REQ-030 SHALL drive out_sum as the live running sum while in ACCUM; it is qualified only by out_valid.

Reset
REQ-031 SHALL apply on rst=1 at a rising edge: state=ACCUM, sum=0, counter=0, out_ovf=0.
REQ-032 SHALL give the resulting output values in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-033 SHALL give rst priority over clear and over all handshakes.
REQ-034 SHALL discard a partial frame when rst is asserted mid-frame.
REQ-035 SHALL present the reset values of REQ-032 from the first edge at which rst is sampled high.

Verification
REQ-036 SHALL cover a no-saturation frame: 7,-8,3,1,-2,0,5,-4 with out_ready=1 -> out_valid for 1 cycle, out_sum=2, out_ovf=0.
REQ-037 SHALL cover positive saturation: eight samples of 7 -> sum clamps at 31 after the fifth sample; out_sum=31 (011111), out_ovf=1.
REQ-038 SHALL cover negative saturation: eight samples of -8 -> out_sum=-32 (100000), out_ovf=1, set on the fifth sample.
REQ-039 SHALL cover backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum stable, no samples counted; then out_ready=1 -> next frame starts from 0.
REQ-040 SHALL cover clear mid-frame: after 3 samples of 7 (sum 21), pulse clear together with in_valid -> sum 0, count 0; the next 8 samples of 1 give out_sum=8.
REQ-041 SHALL cover reset in HOLD: rst=1 while out_valid=1 -> next cycle out_valid=0, in_ready=1, out_sum=0, out_ovf=0.
